// File: rtl/writeback_stage_if.sv
// Bundles the execute-to-writeback signals and the writeback results of writeback_stage.
// The master side is the execute stage; the slave side is the writeback stage.
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic                  exe_reg_en;
    logic                  exe_mem_read;
    logic [REG_AW-1:0]     exe_reg_waddr;
    logic [DATA_W-1:0]     alu_result_reg;
    logic [2:0]            exe_load_type;
    logic [DATA_W-1:0]     exe_load_rt_data;
    logic [DATA_W-1:0]     data_sram_rdata;
    logic                  exe_MD_complete;
    logic [2*DATA_W-1:0]   exe_MD_result;
    logic                  exe_hi_wen;
    logic                  exe_lo_wen;
    logic [1:0]            exe_mf_sel;
    logic                  wb_reg_wen;
    logic [REG_AW-1:0]     wb_reg_waddr;
    logic [DATA_W-1:0]     wb_reg_wdata;
    logic [DATA_W-1:0]     hi_out;
    logic [DATA_W-1:0]     lo_out;

    modport master (
        output exe_reg_en, exe_mem_read, exe_reg_waddr, alu_result_reg,
               exe_load_type, exe_load_rt_data, data_sram_rdata,
               exe_MD_complete, exe_MD_result, exe_hi_wen, exe_lo_wen, exe_mf_sel,
        input  wb_reg_wen, wb_reg_waddr, wb_reg_wdata, hi_out, lo_out
    );

    modport slave (
        input  exe_reg_en, exe_mem_read, exe_reg_waddr, alu_result_reg,
               exe_load_type, exe_load_rt_data, data_sram_rdata,
               exe_MD_complete, exe_MD_result, exe_hi_wen, exe_lo_wen, exe_mf_sel,
        output wb_reg_wen, wb_reg_waddr, wb_reg_wdata, hi_out, lo_out
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: load-data extraction, HI/LO ownership, registered GPR write port.
// Optional macro HILO_BYPASS_EN lets MFHI/MFLO see the value HI/LO take at the same edge.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               resetn,
    writeback_stage_if.slave   bus
);

    logic [1:0]         w_addr_lo;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [DATA_W-1:0]  w_mem;
    logic [DATA_W-1:0]  w_rt;
    logic [DATA_W-1:0]  w_load_data;
    logic [DATA_W-1:0]  w_hi_next;
    logic [DATA_W-1:0]  w_lo_next;
    logic [DATA_W-1:0]  w_mf_hi;
    logic [DATA_W-1:0]  w_mf_lo;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_wen;

    logic               r_wb_reg_wen;
    logic [REG_AW-1:0]  r_wb_reg_waddr;
    logic [DATA_W-1:0]  r_wb_reg_wdata;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;

    assign w_addr_lo = bus.alu_result_reg[1:0];
    assign w_mem     = bus.data_sram_rdata;
    assign w_rt      = bus.exe_load_rt_data;

    // Byte and halfword lanes selected by the low address bits; odd halfword addresses yield zero.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        case (w_addr_lo)
            2'd0:    w_byte = w_mem[7:0];
            2'd1:    w_byte = w_mem[15:8];
            2'd2:    w_byte = w_mem[23:16];
            2'd3:    w_byte = w_mem[31:24];
            default: w_byte = 8'h00;
        endcase
        case (w_addr_lo)
            2'd0:    w_half = w_mem[15:0];
            2'd2:    w_half = w_mem[31:16];
            default: w_half = 16'h0000;
        endcase
    end

    // Load result formatting, including the LWL/LWR merge with the old rt value.
    always_comb begin
        w_load_data = w_mem;
        case (bus.exe_load_type)
            3'b000: w_load_data = w_mem;
            3'b001: w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            3'b010: w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            3'b011: w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
            3'b100: w_load_data = {{(DATA_W-16){1'b0}}, w_half};
            3'b101: begin
                case (w_addr_lo)
                    2'd0:    w_load_data = {w_mem[7:0],  w_rt[23:0]};
                    2'd1:    w_load_data = {w_mem[15:0], w_rt[15:0]};
                    2'd2:    w_load_data = {w_mem[23:0], w_rt[7:0]};
                    2'd3:    w_load_data = w_mem;
                    default: w_load_data = w_mem;
                endcase
            end
            3'b110: begin
                case (w_addr_lo)
                    2'd0:    w_load_data = w_mem;
                    2'd1:    w_load_data = {w_rt[31:24], w_mem[31:8]};
                    2'd2:    w_load_data = {w_rt[31:16], w_mem[31:16]};
                    2'd3:    w_load_data = {w_rt[31:8],  w_mem[31:24]};
                    default: w_load_data = w_mem;
                endcase
            end
            default: w_load_data = w_mem;
        endcase
    end

    // Next HI/LO: MTHI/MTLO are younger than a completing MD op and therefore win.
    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (bus.exe_hi_wen) begin
            w_hi_next = bus.alu_result_reg;
        end else if (bus.exe_MD_complete) begin
            w_hi_next = bus.exe_MD_result[2*DATA_W-1:DATA_W];
        end else begin
            w_hi_next = r_hi;
        end
        if (bus.exe_lo_wen) begin
            w_lo_next = bus.alu_result_reg;
        end else if (bus.exe_MD_complete) begin
            w_lo_next = bus.exe_MD_result[DATA_W-1:0];
        end else begin
            w_lo_next = r_lo;
        end
    end

`ifdef HILO_BYPASS_EN
    assign w_mf_hi = w_hi_next;
    assign w_mf_lo = w_lo_next;
`else
    // Without bypass the hazard unit keeps MF one cycle behind a completing MD op.
    assign w_mf_hi = r_hi;
    assign w_mf_lo = r_lo;
`endif

    // Write-data source priority: load path, then MFHI, then MFLO, then the ALU result.
    always_comb begin
        w_wdata = bus.alu_result_reg;
        w_wen   = bus.exe_reg_en & (bus.exe_reg_waddr != {REG_AW{1'b0}});
        if (bus.exe_mem_read) begin
            w_wdata = w_load_data;
        end else begin
            case (bus.exe_mf_sel)
                2'b01:   w_wdata = w_mf_hi;
                2'b10:   w_wdata = w_mf_lo;
                default: w_wdata = bus.alu_result_reg;
            endcase
        end
    end

    // Register-file write port; r0 writes keep address/data but drop the enable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wb_reg_wen   <= 1'b0;
            r_wb_reg_waddr <= {REG_AW{1'b0}};
            r_wb_reg_wdata <= {DATA_W{1'b0}};
        end else begin
            r_wb_reg_wen   <= w_wen;
            r_wb_reg_waddr <= bus.exe_reg_waddr;
            r_wb_reg_wdata <= w_wdata;
        end
    end

    // Architectural HI/LO registers; reset discards any in-flight MD completion.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi <= {DATA_W{1'b0}};
            r_lo <= {DATA_W{1'b0}};
        end else begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
        end
    end

    assign bus.wb_reg_wen   = r_wb_reg_wen;
    assign bus.wb_reg_waddr = r_wb_reg_waddr;
    assign bus.wb_reg_wdata = r_wb_reg_wdata;
    assign bus.hi_out       = r_hi;
    assign bus.lo_out       = r_lo;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expectations are queued as stimulus is driven
// and compared one edge later against the registered write port and HI/LO.
module tb_writeback_stage;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] a,
                                               input logic [31:0] m, input logic [31:0] r);
        int          sh;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] keep;
        sh = 8 * int'(a);
        b  = (m >> sh) & 32'h0000_00FF;
        h  = 32'h0;
        if (a == 2'd0) h = m & 32'h0000_FFFF;
        if (a == 2'd2) h = m >> 16;
        case (lt)
            3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd2: return b;
            3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4: return h;
            3'd5: begin
                keep = (a == 2'd3) ? 32'h0 : (32'hFFFF_FFFF >> (sh + 8));
                return (m << (24 - sh)) | (r & keep);
            end
            3'd6: begin
                keep = ~(32'hFFFF_FFFF >> sh);
                return (m >> sh) | (r & keep);
            end
            default: return m;
        endcase
    endfunction

    task automatic idle();
        bus.exe_reg_en       = 1'b0;
        bus.exe_mem_read     = 1'b0;
        bus.exe_reg_waddr    = 5'd0;
        bus.alu_result_reg   = 32'h0;
        bus.exe_load_type    = 3'd0;
        bus.exe_load_rt_data = 32'h0;
        bus.data_sram_rdata  = 32'h0;
        bus.exe_MD_complete  = 1'b0;
        bus.exe_MD_result    = 64'h0;
        bus.exe_hi_wen       = 1'b0;
        bus.exe_lo_wen       = 1'b0;
        bus.exe_mf_sel       = 2'd0;
    endtask

    // Compute expectation from current inputs, push it, clock once, pop and compare.
    task automatic step(input string tag);
        exp_t        e;
        exp_t        got;
        logic [31:0] nhi;
        logic [31:0] nlo;
        logic [31:0] mfh;
        logic [31:0] mfl;
        if (!resetn) begin
            m_hi = 32'h0;
            m_lo = 32'h0;
            e.wen = 1'b0; e.waddr = 5'd0; e.wdata = 32'h0; e.hi = 32'h0; e.lo = 32'h0;
        end else begin
            nhi = bus.exe_hi_wen ? bus.alu_result_reg :
                  (bus.exe_MD_complete ? bus.exe_MD_result[63:32] : m_hi);
            nlo = bus.exe_lo_wen ? bus.alu_result_reg :
                  (bus.exe_MD_complete ? bus.exe_MD_result[31:0] : m_lo);
`ifdef HILO_BYPASS_EN
            mfh = nhi; mfl = nlo;
`else
            mfh = m_hi; mfl = m_lo;
`endif
            if (bus.exe_mem_read)
                e.wdata = model_load(bus.exe_load_type, bus.alu_result_reg[1:0],
                                     bus.data_sram_rdata, bus.exe_load_rt_data);
            else if (bus.exe_mf_sel == 2'b01) e.wdata = mfh;
            else if (bus.exe_mf_sel == 2'b10) e.wdata = mfl;
            else e.wdata = bus.alu_result_reg;
            e.wen   = bus.exe_reg_en && (bus.exe_reg_waddr != 5'd0);
            e.waddr = bus.exe_reg_waddr;
            e.hi    = nhi;
            e.lo    = nlo;
            m_hi    = nhi;
            m_lo    = nlo;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'h1, 32'h0);
        end else begin
            got = sb.pop_front();
            chk({tag, ".wen"},   {31'h0, bus.wb_reg_wen}, {31'h0, got.wen});
            chk({tag, ".waddr"}, {27'h0, bus.wb_reg_waddr}, {27'h0, got.waddr});
            chk({tag, ".wdata"}, bus.wb_reg_wdata, got.wdata);
            chk({tag, ".hi"},    bus.hi_out, got.hi);
            chk({tag, ".lo"},    bus.lo_out, got.lo);
        end
    endtask

    task automatic load(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                        input logic [31:0] m, input logic [31:0] r);
        idle();
        bus.exe_reg_en = 1'b1; bus.exe_mem_read = 1'b1; bus.exe_reg_waddr = 5'd5;
        bus.exe_load_type = lt; bus.alu_result_reg = addr;
        bus.data_sram_rdata = m; bus.exe_load_rt_data = r;
        step(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        idle();
        resetn = 1'b0;
        #1;
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd7; bus.alu_result_reg = 32'hDEAD_BEEF;
        bus.exe_MD_complete = 1'b1; bus.exe_MD_result = 64'h1111_1111_2222_2222;
        step("rst0");
        step("rst1");

        resetn = 1'b1;
        idle();
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd3; bus.alu_result_reg = 32'h0000_0011;
        step("first");

        load("lb3",  3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        load("lbu3", 3'd2, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        load("lh2",  3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        load("lhu0", 3'd4, 32'h0000_1000, 32'h80FF_7F01, 32'h0);
        load("lh1",  3'd3, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        load("lwl1", 3'd5, 32'h0000_2001, 32'h4433_2211, 32'hAABB_CCDD);
        load("lwr2", 3'd6, 32'h0000_2002, 32'h4433_2211, 32'hAABB_CCDD);
        load("lt7",  3'd7, 32'h0000_2002, 32'h4433_2211, 32'hAABB_CCDD);

        idle();
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd0; bus.alu_result_reg = 32'h0000_1234;
        step("r0");

        idle();
        bus.exe_MD_complete = 1'b1; bus.exe_MD_result = 64'h0000_0001_0000_0002;
        step("md12");

        idle();
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd8; bus.exe_mf_sel = 2'b10;
        bus.exe_MD_complete = 1'b1; bus.exe_MD_result = 64'h0000_0003_0000_0007;
        step("mflo_same");

        idle();
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd8; bus.exe_mf_sel = 2'b10;
        step("mflo_next");

        idle();
        bus.exe_MD_complete = 1'b1; bus.exe_MD_result = 64'h0000_0005_0000_0006;
        bus.exe_hi_wen = 1'b1; bus.alu_result_reg = 32'h0000_0009;
        step("mthi_md");

        idle();
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd9; bus.exe_mf_sel = 2'b01;
        bus.exe_lo_wen = 1'b1; bus.alu_result_reg = 32'h0000_00AB;
        step("mfhi_mtlo");

        idle();
        bus.exe_reg_en = 1'b1; bus.exe_reg_waddr = 5'd9; bus.exe_mf_sel = 2'b11;
        bus.alu_result_reg = 32'h0BAD_CAFE;
        step("mf3");

        for (int i = 0; i < 60; i++) begin
            bus.exe_reg_en       = 1'($urandom_range(0, 1));
            bus.exe_mem_read     = 1'($urandom_range(0, 1));
            bus.exe_reg_waddr    = 5'($urandom_range(0, 31));
            bus.alu_result_reg   = $urandom;
            bus.exe_load_type    = 3'($urandom_range(0, 7));
            bus.exe_load_rt_data = $urandom;
            bus.data_sram_rdata  = $urandom;
            bus.exe_MD_complete  = ($urandom_range(0, 3) == 0);
            bus.exe_MD_result    = {$urandom, $urandom};
            bus.exe_hi_wen       = ($urandom_range(0, 3) == 0);
            bus.exe_lo_wen       = ($urandom_range(0, 3) == 0);
            bus.exe_mf_sel       = 2'($urandom_range(0, 3));
            step("rnd");
        end

        resetn = 1'b0;
        idle();
        bus.exe_MD_complete = 1'b1; bus.exe_MD_result = 64'hFFFF_FFFF_FFFF_FFFF;
        step("rst_md");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
